// File: rtl/dm_ram_be.sv
// rtl/dm_ram_be.sv - 16 KiB byte-enabled data memory, one synchronous read-first port
// Byte lanes come from access size and addr[1:0]; rdata is the raw word, extension is downstream.
module dm_ram_be #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic              is_byte,
   input  logic              is_half,
   input  logic [ADDR_W+1:0] addr,
   input  logic [31:0]       wdata,
   output logic [3:0]        be,
   output logic [31:0]       wdata_lane,
   output logic [31:0]       rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [0:DEPTH-1] = '{default: '0};
   logic [ADDR_W-1:0] word;
   logic [3:0]        wen;

   assign word = addr[ADDR_W+1:2];

   // Byte wins over half; a misaligned half falls back to its containing halfword.
   always_comb begin
      be = 4'b1111;
      if (is_byte)
         be = 4'b0001 << addr[1:0];
      else if (is_half)
         be = addr[1] ? 4'b1100 : 4'b0011;
   end

   assign wdata_lane = wdata << {addr[1:0], 3'b000};
   assign wen        = {4{en & we}} & be;

   // Non-blocking read of mem before the lane writes gives read-first behaviour;
   // holding writes under rst drops any store coinciding with reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         if (en)
            rdata <= mem[word];
         for (int i = 0; i < 4; i++)
            if (wen[i])
               mem[word][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_dm_ram_be.sv
// tb/tb_dm_ram_be.sv - self-checking bench for dm_ram_be against a byte-addressed model
module tb_dm_ram_be;

   localparam int AW = 12;
   localparam int NBYTES = 4 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en, we, is_byte, is_half;
   logic [AW+1:0] addr;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic [31:0]   wdata_lane;
   logic [31:0]   rdata;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem_b [0:NBYTES-1];
   logic [31:0] exp_rdata;

   dm_ram_be #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .we         (we),
      .is_byte    (is_byte),
      .is_half    (is_half),
      .addr       (addr),
      .wdata      (wdata),
      .be         (be),
      .wdata_lane (wdata_lane),
      .rdata      (rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_be(input bit b, input bit h, input int off);
      logic [3:0] r;
      for (int k = 0; k < 4; k++) begin
         if (b)      r[k] = (k == off);
         else if (h) r[k] = (k / 2 == off / 2);
         else        r[k] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [31:0] model_lane(input logic [31:0] d, input int off);
      logic [63:0] t;
      t = 64'(d) * (64'd1 << (8 * off));
      return t[31:0];
   endfunction

   function automatic logic [31:0] model_word(input int w);
      return {mem_b[4*w+3], mem_b[4*w+2], mem_b[4*w+1], mem_b[4*w]};
   endfunction

   // One clock of stimulus: checks combinational outputs, then rdata after the edge.
   task automatic cyc(input string tag, input bit e, input bit w, input bit b, input bit h,
                      input logic [13:0] a, input logic [31:0] d);
      logic [3:0]  xb;
      logic [31:0] xl;
      int          wd;
      int          off;
      en = e; we = w; is_byte = b; is_half = h; addr = a; wdata = d;
      off = int'(a[1:0]);
      #1;
      xb = model_be(b, h, off);
      xl = model_lane(d, off);
      check({tag, "_be"}, {28'b0, be}, {28'b0, xb});
      check({tag, "_lane"}, wdata_lane, xl);
      @(posedge clk);
      wd = int'(a[13:2]);
      if (rst) begin
         exp_rdata = 32'h0;
      end else if (e) begin
         exp_rdata = model_word(wd);
         if (w)
            for (int k = 0; k < 4; k++)
               if (xb[k]) mem_b[4*wd+k] = xl[8*k +: 8];
      end
      #1;
      check({tag, "_rd"}, rdata, exp_rdata);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
      exp_rdata = 32'h0;
      rst = 1'b1; en = 1'b0; we = 1'b0; is_byte = 1'b0; is_half = 1'b0;
      addr = '0; wdata = '0;
      #1;
      check("reset_rdata", rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int a = 0; a < 4; a++) begin
         cyc("be_byte", 1'b0, 1'b0, 1'b1, 1'b0, 14'(a), 32'h000000C3);
         cyc("be_half", 1'b0, 1'b0, 1'b0, 1'b1, 14'(a), 32'h0000A55A);
         cyc("be_word", 1'b0, 1'b0, 1'b0, 1'b0, 14'(a), 32'h12345678);
      end
      cyc("be_both", 1'b0, 1'b0, 1'b1, 1'b1, 14'h2, 32'h0);
      check("be_both_const", {28'b0, be}, 32'h4);

      cyc("st_word", 1'b1, 1'b1, 1'b0, 1'b0, 14'h0010, 32'hDEADBEEF);
      cyc("ld_word", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0010, 32'h0);
      check("ld_word_const", rdata, 32'hDEADBEEF);

      cyc("pre_20", 1'b1, 1'b1, 1'b0, 1'b0, 14'h0020, 32'h11223344);
      en = 1'b1; we = 1'b1; is_byte = 1'b1; is_half = 1'b0; addr = 14'h0022; wdata = 32'hAB;
      #1;
      check("stb_lane_const", wdata_lane, 32'h00AB0000);
      check("stb_be_const", {28'b0, be}, 32'h4);
      cyc("st_byte", 1'b1, 1'b1, 1'b1, 1'b0, 14'h0022, 32'h000000AB);
      cyc("ld_byte", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0020, 32'h0);
      check("ld_byte_const", rdata, 32'h11AB3344);
      cyc("st_half", 1'b1, 1'b1, 1'b0, 1'b1, 14'h0020, 32'h0000CDEF);
      cyc("ld_half", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0020, 32'h0);
      check("ld_half_const", rdata, 32'h11ABCDEF);

      cyc("rf_wr", 1'b1, 1'b1, 1'b1, 1'b0, 14'h0020, 32'h00000055);
      check("rf_old_const", rdata, 32'h11ABCDEF);
      cyc("rf_rd", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0020, 32'h0);
      check("rf_new_const", rdata, 32'h11ABCD55);
      cyc("hold", 1'b0, 1'b1, 1'b0, 1'b0, 14'h0040, 32'hFFFFFFFF);
      check("hold_const", rdata, 32'h11ABCD55);
      cyc("hold_rd", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0040, 32'h0);
      check("hold_mem_const", rdata, 32'h0);

      cyc("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0010, 32'h0);
      #2 rst = 1'b1;
      #1;
      exp_rdata = 32'h0;
      check("async_rst", rdata, 32'h0);
      cyc("rst_wr", 1'b1, 1'b1, 1'b0, 1'b0, 14'h0030, 32'h12345678);
      rst = 1'b0;
      cyc("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0010, 32'h0);
      check("post_rst_const", rdata, 32'hDEADBEEF);
      cyc("rst_wr_rd", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0030, 32'h0);
      check("rst_wr_const", rdata, 32'h0);

      cyc("top_wr", 1'b1, 1'b1, 1'b0, 1'b0, 14'h3FFC, 32'hA5A5A5A5);
      cyc("top_rd", 1'b1, 1'b0, 1'b0, 1'b0, 14'h3FFC, 32'h0);
      check("top_const", rdata, 32'hA5A5A5A5);
      cyc("w0_rd", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0);
      check("w0_const", rdata, 32'h0);

      for (int i = 0; i < 400; i++) begin
         logic [13:0] ra;
         ra = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 63));
         cyc("rnd", $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
             ra, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
